// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI codes, default sideband constants and line master FSM states
package axi_pkg;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE} line_state_e;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [3:0] AXI_ID_DEFAULT = 4'd0;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'd0;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'd0;
  localparam logic AXI_LOCK_DEFAULT = 1'b0;
endpackage

// File: rtl/axi_line_buf.sv
// axi_line_buf: line register with whole-line load plus indexed word write/read
module axi_line_buf #(
  parameter int WORDS = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [WORDS*WIDTH-1:0]     load_line,
  input  logic                       we,
  input  logic [$clog2(WORDS)-1:0]   idx,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WORDS*WIDTH-1:0]     line,
  output logic [WIDTH-1:0]           word
);
  always_ff @(posedge clk or posedge reset)
    if (reset) line <= '0;
    else if (load) line <= load_line;
    else if (we) line[idx*WIDTH +: WIDTH] <= wdata;
  assign word = line[idx*WIDTH +: WIDTH];
endmodule

// File: rtl/axi_line_master.sv
// axi_line_master: turns CPU line refill/write-back requests into single AXI INCR bursts
module axi_line_master
  import axi_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_wr,
  input  logic [BUS_WIDTH-1:0]             req_addr,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wdata,
  output logic                             resp_valid,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_rdata,
  output logic                             resp_err,
  output logic                             ar_valid,
  input  logic                             ar_ready,
  output logic [BUS_WIDTH-1:0]             ar_addr,
  output logic [7:0]                       ar_len,
  output logic [3:0]                       ar_id,
  output logic [2:0]                       ar_size,
  output logic [1:0]                       ar_burst,
  output logic [2:0]                       ar_prot,
  output logic                             ar_lock,
  output logic [3:0]                       ar_cache,
  input  logic                             rd_valid,
  output logic                             rd_ready,
  input  logic [DATA_WIDTH-1:0]            rd_data,
  input  logic [1:0]                       rd_resp,
  input  logic                             rd_last,
  input  logic [3:0]                       rd_id,
  output logic                             aw_valid,
  input  logic                             aw_ready,
  output logic [BUS_WIDTH-1:0]             aw_addr,
  output logic [7:0]                       aw_len,
  output logic [3:0]                       aw_id,
  output logic [2:0]                       aw_size,
  output logic [1:0]                       aw_burst,
  output logic [2:0]                       aw_prot,
  output logic                             aw_lock,
  output logic [3:0]                       aw_cache,
  output logic                             wd_valid,
  input  logic                             wd_ready,
  output logic [DATA_WIDTH-1:0]            wd_data,
  output logic [DATA_WIDTH/8-1:0]          wstrb,
  output logic                             wd_last,
  output logic [3:0]                       wd_id,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [1:0]                       wr_breap,
  input  logic [3:0]                       wr_id
);
  localparam int BW = $clog2(LINE_WORDS);
  localparam int OFS = $clog2(LINE_WORDS*DATA_WIDTH/8);
  localparam logic [BW-1:0] LAST = BW'(LINE_WORDS-1);
  line_state_e state, state_n;
  logic [BW-1:0] beat_cnt;
  logic err, accept, rd_beat, wd_beat;
  logic [BUS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] unused_rword;
  logic [LINE_WORDS*DATA_WIDTH-1:0] unused_wline;
  logic unused_ok;
  assign req_ready = state == IDLE && !reset;
  assign accept = req_valid && req_ready;
  assign rd_ready = state == RD_DATA;
  assign rd_beat = rd_ready && rd_valid;
  assign wd_valid = state == WR_DATA;
  assign wd_beat = wd_valid && wd_ready;
  assign wd_last = wd_valid && beat_cnt == LAST;
  assign wr_ready = state == WR_RESP;
  assign ar_valid = state == RD_ADDR;
  assign aw_valid = state == WR_ADDR;
  assign resp_valid = state == DONE;
  assign resp_err = resp_valid && err;
  assign ar_addr = addr_q;
  assign aw_addr = addr_q;
  assign ar_len = 8'(LINE_WORDS-1);
  assign aw_len = 8'(LINE_WORDS-1);
  assign wstrb = '1;
  assign {ar_id, aw_id, wd_id} = {3{AXI_ID_DEFAULT}};
  assign ar_size = 3'($clog2(DATA_WIDTH/8));
  assign aw_size = 3'($clog2(DATA_WIDTH/8));
  assign {ar_burst, aw_burst} = {2{AXI_BURST_INCR}};
  assign {ar_prot, aw_prot} = {2{AXI_PROT_DEFAULT}};
  assign {ar_lock, aw_lock} = {2{AXI_LOCK_DEFAULT}};
  assign {ar_cache, aw_cache} = {2{AXI_CACHE_DEFAULT}};
  assign unused_ok = ^{rd_id, wr_id, rd_resp[0], wr_breap[0], req_addr[OFS-1:0]};
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (req_wr ? WR_ADDR : RD_ADDR) : IDLE;
      RD_ADDR: state_n = ar_ready ? RD_DATA : RD_ADDR;
      RD_DATA: state_n = rd_beat && rd_last ? DONE : RD_DATA;
      WR_ADDR: state_n = aw_ready ? WR_DATA : WR_ADDR;
      WR_DATA: state_n = wd_beat && wd_last ? WR_RESP : WR_DATA;
      WR_RESP: state_n = wr_valid ? DONE : WR_RESP;
      default: state_n = IDLE;
    endcase
  end
  // a short burst (rd_last before the final word) is flagged as an error
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      beat_cnt <= '0;
      err <= 1'b0;
      addr_q <= '0;
    end else begin
      state <= state_n;
      if (accept) addr_q <= {req_addr[BUS_WIDTH-1:OFS], OFS'(0)};
      beat_cnt <= state == DONE ? '0 : beat_cnt + BW'(rd_beat || wd_beat);
      err <= state == DONE ? 1'b0 :
             err | (rd_beat && (rd_resp[1] || (rd_last && beat_cnt != LAST))) |
             (wr_ready && wr_valid && wr_breap[1]);
    end
  axi_line_buf #(.WORDS(LINE_WORDS), .WIDTH(DATA_WIDTH)) u_rbuf (
    .clk(clk), .reset(reset), .load(1'b0), .load_line('0), .we(rd_beat),
    .idx(beat_cnt), .wdata(rd_data), .line(resp_rdata), .word(unused_rword)
  );
  axi_line_buf #(.WORDS(LINE_WORDS), .WIDTH(DATA_WIDTH)) u_wbuf (
    .clk(clk), .reset(reset), .load(accept), .load_line(req_wdata), .we(1'b0),
    .idx(beat_cnt), .wdata('0), .line(unused_wline), .word(wd_data)
  );
endmodule
